// File: rtl/alu_mul_seq.sv
// Shift-add 32x32->64 multiply sequencer that borrows the core's ALU, arbitrating it against the core.
// Optional signed operands are enabled by defining MUL_SIGNED_EN.
module alu_mul_seq #(
  parameter logic [2:0] ALU_ADD_OP = 3'd2,
  parameter int         ITER       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
`ifdef MUL_SIGNED_EN
  input  logic        req_signed,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_prod,
  input  logic [2:0]  core_ctrl,
  input  logic [31:0] core_a,
  input  logic [31:0] core_b,
  input  logic [4:0]  core_shamt,
  output logic        core_stall,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_r,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  state_t      state_r, state_s;
  logic [31:0] mcand_r, hi_r, lo_r;
  logic [4:0]  cnt_r;
  logic [32:0] step_s;
  logic [63:0] shift_s, prod_next_s;
  logic [31:0] mcand_load_s, lo_load_s;
  logic        last_s;
`ifdef MUL_SIGNED_EN
  logic        neg_r;
`endif

  // Magnitude of a two's-complement word when signed interpretation is requested.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == DONE);
  assign core_stall = (state_r != IDLE);
  assign resp_prod  = {hi_r, lo_r};

  // Next state and ALU ownership mux.
  always_comb begin
    state_s   = state_r;
    alu_ctrl  = core_ctrl;
    alu_a     = core_a;
    alu_b     = core_b;
    alu_shamt = core_shamt;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        alu_ctrl  = ALU_ADD_OP;
        alu_a     = hi_r;
        alu_b     = mcand_r;
        alu_shamt = 5'd0;
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (resp_ready) state_s = IDLE;
        else            state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // One shift-add step: the ALU sum (with carry) is kept only when the multiplier LSB is set.
  always_comb begin
    last_s  = (cnt_r == LAST_CNT);
    step_s  = lo_r[0] ? {alu_cout, alu_r} : {1'b0, hi_r};
    shift_s = {step_s, lo_r[31:1]};
`ifdef MUL_SIGNED_EN
    if (last_s && neg_r) prod_next_s = ~shift_s + 64'd1;
    else                 prod_next_s = shift_s;
    mcand_load_s = mag32(req_a, req_signed);
    lo_load_s    = mag32(req_b, req_signed);
`else
    prod_next_s  = shift_s;
    mcand_load_s = mag32(req_a, 1'b0);
    lo_load_s    = mag32(req_b, 1'b0);
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mcand_r <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      cnt_r   <= 5'd0;
`ifdef MUL_SIGNED_EN
      neg_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            mcand_r <= mcand_load_s;
            lo_r    <= lo_load_s;
            hi_r    <= 32'd0;
            cnt_r   <= 5'd0;
`ifdef MUL_SIGNED_EN
            neg_r   <= req_signed & (req_a[31] ^ req_b[31]);
`endif
          end
        end
        RUN: begin
          {hi_r, lo_r} <= prod_next_s;
          cnt_r        <= cnt_r + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: arithmetic reference model with per-cycle compare plus directed vectors.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, resp_valid, resp_ready, core_stall, alu_cout;
  logic [31:0] req_a, req_b, core_a, core_b, alu_a, alu_b, alu_r;
  logic [63:0] resp_prod;
  logic [2:0]  core_ctrl, alu_ctrl;
  logic [4:0]  core_shamt, alu_shamt;
`ifdef MUL_SIGNED_EN
  logic        req_signed;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
`ifdef MUL_SIGNED_EN
    .req_signed(req_signed),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_prod(resp_prod),
    .core_ctrl(core_ctrl), .core_a(core_a), .core_b(core_b), .core_shamt(core_shamt),
    .core_stall(core_stall),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_r(alu_r), .alu_cout(alu_cout)
  );

  // Stand-in for the processor's combinational ALU: ADD (code 2) with carry, AND otherwise.
  assign {alu_cout, alu_r} = (alu_ctrl == 3'd2) ? ({1'b0, alu_a} + {1'b0, alu_b})
                                                : {1'b0, alu_a & alu_b};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    if (sg) return 64'(sa * sb);
    else    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] a, input logic sg);
    if (sg && a[31]) return 32'd0 - a;
    else             return a;
  endfunction

  // Reference model: 0 idle, 1 busy for 32 cycles, 2 holding the product.
  int          phase = 0;
  int          runs  = 0;
  logic [63:0] m_prod = 64'd0;
  logic [31:0] m_mcand = 32'd0;
  bit          chk_en = 1'b0;
  logic        cur_sg;

`ifdef MUL_SIGNED_EN
  assign cur_sg = req_signed;
`else
  assign cur_sg = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      phase <= 0;
    end else begin
      case (phase)
        0: if (req_valid) begin
             phase   <= 1;
             runs    <= 0;
             m_prod  <= ref_mul(req_a, req_b, cur_sg);
             m_mcand <= ref_mag(req_a, cur_sg);
           end
        1: begin
             runs <= runs + 1;
             if (runs == 31) phase <= 2;
           end
        2: if (resp_ready) phase <= 0;
        default: phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",  64'(req_ready),  64'(phase == 0));
      chk("core_stall", 64'(core_stall), 64'(phase != 0));
      chk("resp_valid", 64'(resp_valid), 64'(phase == 2));
      if (phase == 2) chk("resp_prod", resp_prod, m_prod);
      if (phase == 1) begin
        chk("run_alu_ctrl",  64'(alu_ctrl),  64'(3'd2));
        chk("run_alu_b",     64'(alu_b),     64'(m_mcand));
        chk("run_alu_shamt", 64'(alu_shamt), 64'd0);
      end else begin
        chk("pass_ctrl",  64'(alu_ctrl),  64'(core_ctrl));
        chk("pass_a",     64'(alu_a),     64'(core_a));
        chk("pass_b",     64'(alu_b),     64'(core_b));
        chk("pass_shamt", 64'(alu_shamt), 64'(core_shamt));
      end
    end
  end

  task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [63:0] expected, input int hold);
    int  n;
    bit  got;
    req_a = a;
    req_b = b;
`ifdef MUL_SIGNED_EN
    req_signed = sg;
`else
    if (sg) $display("signed vector %s skipped in unsigned build", name);
`endif
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid) got = 1'b1;
    end
    chk({name, "_latency"}, 64'(n), 64'd32);
    chk(name, resp_prod, expected);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_held"}, resp_prod, expected);
      chk({name, "_held_ready"}, 64'(req_ready), 64'd0);
      chk({name, "_held_stall"}, 64'(core_stall), 64'd1);
    end
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_back_idle"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    req_a = 32'd0;
    req_b = 32'd0;
`ifdef MUL_SIGNED_EN
    req_signed = 1'b0;
`endif
    core_ctrl = 3'd0;
    core_a = 32'hAAAAAAAA;
    core_b = 32'hFFFFFFFF;
    core_shamt = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod",  resp_prod,         64'd0);
    chk("rst_ready", 64'(req_ready),    64'd1);
    chk("rst_valid", 64'(resp_valid),   64'd0);
    chk("rst_stall", 64'(core_stall),   64'd0);
    chk("idle_alu_a", 64'(alu_a),       64'hAAAAAAAA);
    chk("idle_alu_b", 64'(alu_b),       64'hFFFFFFFF);
    chk_en = 1'b1;
    rst_n = 1'b1;

    do_mul("mul_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 0);
    core_ctrl = 3'd5; core_a = 32'h12345678; core_b = 32'h0F0F0F0F; core_shamt = 5'd31;
    do_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 0);
    do_mul("mul_msb", 32'h80000000, 32'd2, 1'b0, 64'h00000001_00000000, 0);
    do_mul("mul_zero", 32'd0, 32'hDEADBEEF, 1'b0, 64'd0, 0);
    do_mul("mul_bp", 32'd24, 32'd20984, 1'b0, 64'd503616, 10);

    // Abort a multiply with reset partway through the iterations.
    req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1;
    @(posedge clk);
    #2 req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", 64'(req_ready),  64'd1);
    chk("midrst_valid", 64'(resp_valid), 64'd0);
    chk("midrst_stall", 64'(core_stall), 64'd0);
    chk("midrst_prod",  resp_prod,       64'd0);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_quiet", 64'(resp_valid), 64'd0);
    do_mul("mul_7x6", 32'd7, 32'd6, 1'b0, 64'd42, 0);

`ifdef MUL_SIGNED_EN
    do_mul("smul_m1x1", 32'hFFFFFFFF, 32'd1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 0);
    do_mul("smul_min", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 0);
    do_mul("smul_neg", 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 2);
    do_mul("umul_m1x1", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
